mem_port_arbiter: RTL and testbench

- Shares the single-port unified instruction/data memory between the IF-stage fetch requester and the MEM-stage load/store requester.
- Arbitrates between them and sequences one memory transaction at a time against a variable-latency memory (mem_ready handshake).
- Returns read data and completion pulses to the winning requester.
- Data port has priority; a starvation counter guarantees fetch forward progress.

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified instruction/data memory between the IF-stage
// fetch requester and the MEM-stage load/store requester. One memory access is
// in flight at a time. The memory may take any number of cycles, signalled by
// mem_ready.
//
// Handshake rules:
//   A requester holds x_req and its address/data stable until it sees x_gnt=1
//   in a cycle. The access is accepted at that rising edge. After acceptance,
//   mem_* stay constant until the memory asserts mem_ready=1. One cycle after
//   the mem_ready cycle, x_rvalid pulses for exactly one cycle.
//
// Arbitration:
//   The data port has priority over fetch. If the data port wins STARVE_MAX
//   consecutive contested arbitrations, fetch wins the next contested one.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   if_req/if_addr           fetch request (read only)
//   if_gnt/if_rvalid/if_rdata  fetch grant, completion pulse, instruction
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request
//   d_gnt/d_rvalid/d_rdata   data grant, completion pulse, load data
//   mem_req/we/be/addr/wdata registered memory command
//   mem_ready/mem_rdata      memory completion and read data
//   dbg_state                current FSM state (0 idle, 1 fetch, 2 data)
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       window;
  logic       pick_d;
  logic       pick_if;

  // The arbitration window also opens on the completing cycle of a busy
  // access. This lets the next access start with no idle bubble.
  always_comb begin
    window  = (state == IDLE) || mem_ready;
    pick_d  = window && d_req && (!if_req || (starve_cnt != STARVE_LIM));
    pick_if = window && if_req && !pick_d;
  end

  // Gated by rst_n so that no grant is advertised while reset is held.
  assign d_gnt     = pick_d && rst_n;
  assign if_gnt    = pick_if && rst_n;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      // Completion of the access that is currently in flight.
      if_rvalid <= (state == BUSY_IF) && mem_ready;
      d_rvalid  <= (state == BUSY_D) && mem_ready;
      if ((state == BUSY_IF) && mem_ready) begin
        if_rdata <= mem_rdata;
      end
      // A store completion leaves d_rdata untouched; only the pulse acknowledges it.
      if ((state == BUSY_D) && mem_ready && !mem_we) begin
        d_rdata <= mem_rdata;
      end

      if (pick_d) begin
        state     <= BUSY_D;
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        // Count only contested wins by the data port, saturating at the limit.
        if (if_req && (starve_cnt != STARVE_LIM)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else if (pick_if) begin
        state      <= BUSY_IF;
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_be     <= '1;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        starve_cnt <= '0;
      end else if ((state != IDLE) && mem_ready) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (AW=32, DW=32, STARVE_MAX=4).
// Inputs are driven 1 ns after each rising edge.
// Registered outputs are checked at that same point.
// Combinational grants are checked 1 ns later, after the inputs have settled.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant pattern for constant contention: 1 = data port, 0 = fetch
  logic [9:0] cont_pat;

  initial begin
    cont_pat  = 10'b0111101111;  // bit i = grant i; D,D,D,D,IF,D,D,D,D,IF
    rst_n     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_be      = 4'h0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    // Reset values
    #12;
    check("rst_mem_req",   64'(mem_req), 64'd0);
    check("rst_mem_we",    64'(mem_we), 64'd0);
    check("rst_mem_be",    64'(mem_be), 64'd0);
    check("rst_mem_addr",  64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_if_gnt",    64'(if_gnt), 64'd0);
    check("rst_d_gnt",     64'(d_gnt), 64'd0);
    check("rst_rvalid",    64'({if_rvalid, d_rvalid}), 64'd0);
    check("rst_rdata",     64'({if_rdata, d_rdata}), 64'd0);
    check("rst_state",     64'(dbg_state), 64'd0);
    if_req = 1'b0;
    rst_n  = 1'b1;
    tick();

    // Single fetch, zero wait states
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    #1;
    check("f_if_gnt", 64'(if_gnt), 64'd1);
    check("f_d_gnt",  64'(d_gnt), 64'd0);
    tick();
    if_req = 1'b0;
    check("f_mem_req",  64'(mem_req), 64'd1);
    check("f_mem_addr", 64'(mem_addr), 64'h10);
    check("f_mem_we",   64'(mem_we), 64'd0);
    check("f_mem_be",   64'(mem_be), 64'hf);
    check("f_rvalid_early", 64'(if_rvalid), 64'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0050_0093;
    tick();
    mem_ready = 1'b0;
    check("f_if_rvalid", 64'(if_rvalid), 64'd1);
    check("f_if_rdata",  64'(if_rdata), 64'h0050_0093);
    check("f_mem_req_drop", 64'(mem_req), 64'd0);
    check("f_state_idle",   64'(dbg_state), 64'd0);
    tick();
    check("f_rvalid_pulse", 64'(if_rvalid), 64'd0);

    // Constant contention with mem_ready tied high
    if_req    = 1'b1;
    if_addr   = 32'h40;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_be      = 4'hf;
    d_addr    = 32'h200;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_0001;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("c_d_gnt_%0d", i),  64'(d_gnt), 64'(cont_pat[i]));
      check($sformatf("c_if_gnt_%0d", i), 64'(if_gnt), 64'(!cont_pat[i]));
      tick();
      check($sformatf("c_mem_addr_%0d", i), 64'(mem_addr), cont_pat[i] ? 64'h200 : 64'h40);
      check($sformatf("c_mem_req_%0d", i),  64'(mem_req), 64'd1);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    check("c_end_if_rvalid", 64'(if_rvalid), 64'd1);
    check("c_end_d_rvalid",  64'(d_rvalid), 64'd0);
    check("c_end_mem_req",   64'(mem_req), 64'd0);
    mem_ready = 1'b0;
    tick();

    // Store with three wait states; d_rdata keeps the last load value
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0011;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    #1;
    check("s_d_gnt", 64'(d_gnt), 64'd1);
    tick();
    d_req = 1'b0;
    d_we  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s_cmd_%0d", k),
            {mem_req, mem_we, mem_be, 26'd0, mem_addr[31:0]},
            {1'b1, 1'b1, 4'b0011, 26'd0, 32'h100});
      check($sformatf("s_wdata_%0d", k), 64'(mem_wdata), 64'hDEAD_BEEF);
      check($sformatf("s_no_rvalid_%0d", k), 64'(d_rvalid), 64'd0);
      mem_ready = (k == 3);
      tick();
    end
    mem_ready = 1'b0;
    check("s_d_rvalid", 64'(d_rvalid), 64'd1);
    check("s_d_rdata",  64'(d_rdata), 64'hA5A5_0001);
    check("s_mem_req",  64'(mem_req), 64'd0);
    tick();
    check("s_rvalid_pulse", 64'(d_rvalid), 64'd0);

    // Back-to-back: load, then the pending fetch is granted in its ready cycle
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h300;
    if_req  = 1'b1;
    if_addr = 32'h80;
    #1;
    check("b_d_gnt",  64'(d_gnt), 64'd1);
    check("b_if_gnt", 64'(if_gnt), 64'd0);
    tick();
    d_req = 1'b0;
    check("b_mem_addr_ld", 64'(mem_addr), 64'h300);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    #1;
    check("b_if_gnt_ready", 64'(if_gnt), 64'd1);
    tick();
    if_req    = 1'b0;
    mem_rdata = 32'h0000_0013;
    check("b_mem_req_held", 64'(mem_req), 64'd1);
    check("b_mem_addr_if",  64'(mem_addr), 64'h80);
    check("b_d_rvalid",     64'(d_rvalid), 64'd1);
    check("b_d_rdata",      64'(d_rdata), 64'h0BAD_F00D);
    tick();
    mem_ready = 1'b0;
    check("b_if_rvalid", 64'(if_rvalid), 64'd1);
    check("b_if_rdata",  64'(if_rdata), 64'h13);
    check("b_mem_req",   64'(mem_req), 64'd0);
    tick();

    // Reset mid-transaction. The data port wins four contested rounds first,
    // so the fetch port is owed the next contested grant; reset must forget that.
    if_req    = 1'b1;
    d_req     = 1'b1;
    d_addr    = 32'h400;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("r_pre_d_gnt_%0d", i), 64'(d_gnt), 64'd1);
      tick();
    end
    mem_ready = 1'b0;
    if_req    = 1'b0;
    d_req     = 1'b0;
    check("r_busy_d", 64'(dbg_state), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_async_mem_req", 64'(mem_req), 64'd0);
    check("r_async_state",   64'(dbg_state), 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("r_no_rvalid_a", 64'(d_rvalid), 64'd0);
    tick();
    check("r_no_rvalid_b", 64'(d_rvalid), 64'd0);
    check("r_no_replay",   64'(mem_req), 64'd0);
    if_req = 1'b1;
    d_req  = 1'b1;
    #1;
    check("r_fresh_d_gnt",  64'(d_gnt), 64'd1);
    check("r_fresh_if_gnt", 64'(if_gnt), 64'd0);
    tick();
    if_req    = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_7777;
    tick();
    mem_ready = 1'b0;
    check("r_post_d_rvalid", 64'(d_rvalid), 64'd1);
    check("r_post_d_rdata",  64'(d_rdata), 64'h7777);
    tick();

    // Spurious ready while idle
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("i_rvalid_%0d", i), 64'({if_rvalid, d_rvalid}), 64'd0);
      check($sformatf("i_state_%0d", i),  64'(dbg_state), 64'd0);
      check($sformatf("i_mem_req_%0d", i), 64'(mem_req), 64'd0);
    end
    check("i_rdata_kept", 64'(d_rdata), 64'h7777);
    mem_ready = 1'b0;
    tick();

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
